sum_seg_display: RTL and testbench
==================================

Name: sum_seg_display

Overview:
Downstream stage for the 4-bit adder's 5-bit result (sum + carry, 0..31).
- Captures one result per valid/ready handshake.
- Converts it to two BCD digits by iterative subtract-10.
- Drives a single time-multiplexed 7-segment digit on the dedicated outputs, alternating tens and units at a MAX_COUNT-cycle refresh rate.

Parameters:
- MAX_COUNT, 10_000_000, clock cycles each digit phase is shown; legal range >= 2; counter width is clog2(MAX_COUNT).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- ena  input  1  design enable; low freezes all state
- sum_in  input  5  adder result {carry, sum[3:0]}
- in_valid  input  1  sum_in is valid this cycle
- in_ready  output  1  block can accept sum_in this cycle
- seg  output  7  segments {g,f,e,d,c,b,a}, active high, registered
- dp  output  1  decimal point; high while the tens phase is shown, registered
- digit_sel  output  1  0 = units phase, 1 = tens phase, registered

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n low at a clk edge):
  - state = IDLE; seg = 0, dp = 0, digit_sel = 0.
  - Refresh counter = 0; tens and units registers = 0.
  - Reset overrides any in-flight conversion.
- ena low: no state, counter or output register changes; in_ready is forced low.
- in_ready = ena && (state != CONVERT). It is combinational from state.
- Handshake: a transfer occurs on an edge where in_valid && in_ready. The block then latches sum_in into work and clears tens_work. The next state is CONVERT.
- States:
  - IDLE: display blank (seg = 0, dp = 0). Leaves only on a transfer.
  - CONVERT: each cycle, if work >= 10 then work -= 10 and tens_work += 1. Otherwise tens <= tens_work, units <= work, and the state goes to SHOW.
    - Conversion latency by input: 0..9 takes 1 cycle, 10..19 takes 2, 20..29 takes 3, 30..31 takes 4.
    - in_valid is ignored during CONVERT.
  - SHOW: displays the digit registers. A transfer in SHOW restarts CONVERT. The old digits remain displayed until the new conversion completes.
- Refresh counter:
  - Free-runs whenever ena is high and state != IDLE.
  - At MAX_COUNT-1 it wraps to 0 and toggles phase.
  - The counter and phase are not reset by new transfers.
- Output registers (one cycle after the digit/phase change):
  - digit_sel <= phase.
  - dp <= phase.
  - seg <= decode(phase ? tens : units).
- Decode table (hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value >= 10 decodes to blank 00. It is unreachable but defined.
- Boundaries:
  - sum_in = 31 (not produced by the adder) shows 3 / 1.
  - in_valid held high in SHOW re-triggers a conversion every time in_ready is high. Same value gives the same display.

Optional Feature:
- Macro: SUM_SEG_LZ_BLANK_EN.
- Defined: leading-zero blanking. During the tens phase with tens == 0, seg = 00 and dp = 1, which keeps the phase marker.
- Undefined: the tens phase shows 3F ("0") for values 0..9.
- Units-phase behaviour is identical in both builds.

Decomposition:
- Package sum_seg_pkg holds:
  - state enum {IDLE, CONVERT, SHOW};
  - SEG_BLANK = 7'h00;
  - the 10-entry digit-to-segment constant table;
  - the PHASE_UNITS / PHASE_TENS constants.
- Sub-module seg7_decode (combinational, 4-bit in, 7-bit out) wraps the table. The top instantiates it once on the phase-muxed digit.

Test Plan (MAX_COUNT = 4):
- Reset: hold rst_n low 2 cycles, then release. Expect seg = 00, dp = 0, digit_sel = 0, in_ready = 1, state IDLE with blank display.
- Transfer sum_in = 7 from IDLE:
  - in_ready low for exactly 1 cycle;
  - then units phase shows seg = 07;
  - after 4 cycles the tens phase shows 3F with dp = 1 (00 with dp = 1 when SUM_SEG_LZ_BLANK_EN is defined);
  - phases alternate every 4 cycles.
- Transfer sum_in = 30 (15+15): in_ready low 4 cycles. Display alternates 4F (tens, dp = 1) and 3F (units, dp = 0).
- Transfer 25 while showing 12:
  - 1 and 2 remain displayed through 3 CONVERT cycles;
  - then 5B (tens) and 6D (units) appear;
  - phase timing is uninterrupted.
- Error cases: in_valid pulses during CONVERT are ignored (digits match the first value). With ena low for 10 cycles mid-SHOW, outputs and counter are frozen and in_ready = 0.
- Assert rst_n during CONVERT of 28: next cycle is IDLE, seg = 00, in_ready = 1, and no digits from 28 ever appear.

Source files
------------

// File: rtl/sum_seg_pkg.sv
// sum_seg_pkg: shared types and constants for the sum_seg_display block.
//   state_e      : controller states (IDLE, CONVERT, SHOW)
//   SEG_BLANK    : all segments off
//   SEG_TABLE    : digit 0..9 to {g,f,e,d,c,b,a} pattern, active high
//   PHASE_UNITS / PHASE_TENS : values of the display phase bit
//   seg_lookup() : table lookup returning SEG_BLANK for values >= 10
package sum_seg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry [d] holds the pattern for digit d (entry 0 is the rightmost field).
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic PHASE_UNITS = 1'b0;
  localparam logic PHASE_TENS  = 1'b1;

  function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
    logic [6:0] pattern;
    if (digit < 4'd10) begin
      pattern = SEG_TABLE[digit];
    end else begin
      pattern = SEG_BLANK;
    end
    return pattern;
  endfunction

endpackage

// File: rtl/sum_seg_display_seg7_decode.sv
// seg7_decode: combinational BCD digit to 7-segment decoder.
//   digit_i : 4-bit digit value (0..9 meaningful, >= 10 decodes blank)
//   seg_o   : segments {g,f,e,d,c,b,a}, active high
module seg7_decode
  import sum_seg_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Table lookup, blank for out-of-range digits.
  always_comb begin
    seg_o = seg_lookup(digit_i);
  end

endmodule

// File: rtl/sum_seg_display.sv
// sum_seg_display: captures a 5-bit adder result over valid/ready, converts it
// to two BCD digits by repeated subtract-10, and drives one time-multiplexed
// 7-segment digit that alternates units and tens every MAX_COUNT cycles.
// Ports:
//   clk, rst_n (synchronous, active low), ena (low freezes everything)
//   sum_in[4:0], in_valid, in_ready  : input handshake
//   seg[6:0], dp, digit_sel          : registered display outputs
// Build option: define SUM_SEG_LZ_BLANK_EN to blank a leading zero in the tens
// phase (dp stays high as the phase marker).
module sum_seg_display
  import sum_seg_pkg::*;
#(
  parameter int MAX_COUNT = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [4:0] sum_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] seg,
  output logic       dp,
  output logic       digit_sel
);

  localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);

  state_e        state_q, state_d;
  logic [4:0]    work_q, work_d;
  logic [1:0]    tens_work_q, tens_work_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  // Set once a conversion has completed; keeps the display blank until then.
  logic          digits_valid_q, digits_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          digit_sel_q, digit_sel_d;

  logic          transfer_s;
  logic          conv_done_s;
  logic [3:0]    shown_digit_s;
  logic [6:0]    dec_seg_s;

  assign transfer_s  = in_valid && in_ready;
  assign conv_done_s = (state_q == CONVERT) && (work_q < 5'd10);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end else begin
      state_q <= state_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (transfer_s) state_d = CONVERT;
        else            state_d = IDLE;
      end
      CONVERT: begin
        if (conv_done_s) state_d = SHOW;
        else             state_d = CONVERT;
      end
      SHOW: begin
        if (transfer_s) state_d = CONVERT;
        else            state_d = SHOW;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready whenever enabled and not mid-conversion.
  always_comb begin
    in_ready = ena && (state_q != CONVERT);
  end

  // Conversion datapath next values.
  always_comb begin
    work_d         = work_q;
    tens_work_d    = tens_work_q;
    tens_d         = tens_q;
    units_d        = units_q;
    digits_valid_d = digits_valid_q;
    if (transfer_s) begin
      work_d      = sum_in;
      tens_work_d = 2'd0;
    end else if (state_q == CONVERT) begin
      if (work_q >= 5'd10) begin
        work_d      = work_q - 5'd10;
        tens_work_d = tens_work_q + 2'd1;
      end else begin
        // Old digits stay on display until this point.
        tens_d         = {2'b00, tens_work_q};
        units_d        = work_q[3:0];
        digits_valid_d = 1'b1;
      end
    end else begin
      work_d = work_q;
    end
  end

  // Refresh counter next values; transfers do not disturb phase timing.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (state_q != IDLE) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign shown_digit_s = (phase_q == PHASE_TENS) ? tens_q : units_q;

  seg7_decode u_decode (
    .digit_i (shown_digit_s),
    .seg_o   (dec_seg_s)
  );

  // Display register next values.
  always_comb begin
    seg_d       = SEG_BLANK;
    dp_d        = 1'b0;
    digit_sel_d = phase_q;
    if (!digits_valid_q) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b0;
    end else begin
      seg_d = dec_seg_s;
      dp_d  = (phase_q == PHASE_TENS);
`ifdef SUM_SEG_LZ_BLANK_EN
      if ((phase_q == PHASE_TENS) && (tens_q == 4'd0)) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = dec_seg_s;
      end
`endif
    end
  end

  // Datapath, refresh counter and display registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q         <= 5'd0;
      tens_work_q    <= 2'd0;
      tens_q         <= 4'd0;
      units_q        <= 4'd0;
      digits_valid_q <= 1'b0;
      cnt_q          <= '0;
      phase_q        <= PHASE_UNITS;
      seg_q          <= SEG_BLANK;
      dp_q           <= 1'b0;
      digit_sel_q    <= 1'b0;
    end else if (ena) begin
      work_q         <= work_d;
      tens_work_q    <= tens_work_d;
      tens_q         <= tens_d;
      units_q        <= units_d;
      digits_valid_q <= digits_valid_d;
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      digit_sel_q    <= digit_sel_d;
    end else begin
      work_q         <= work_q;
      cnt_q          <= cnt_q;
      seg_q          <= seg_q;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_sum_seg_display.sv
// Directed self-checking bench for sum_seg_display with MAX_COUNT = 4.
module tb_sum_seg_display;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [4:0] sum_in;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] seg;
  logic       dp;
  logic       digit_sel;

  int n_checks;
  int n_errors;

`ifdef SUM_SEG_LZ_BLANK_EN
  localparam logic [6:0] TENS_ZERO = 7'h00;
`else
  localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

  sum_seg_display #(.MAX_COUNT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sum_in    (sum_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ena      = 1'b1;
    in_valid = 1'b0;
    sum_in   = 5'd0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic check_disp(input string tag, input logic [6:0] s, input logic d, input logic sel);
    check_eq({tag, ".seg"}, 32'(seg), 32'(s));
    check_eq({tag, ".dp"}, 32'(dp), 32'(d));
    check_eq({tag, ".sel"}, 32'(digit_sel), 32'(sel));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset state
    do_reset();
    check_disp("rst", 7'h00, 1'b0, 1'b0);
    check_eq("rst.ready", 32'(in_ready), 32'd1);

    // sum_in = 7 from IDLE
    sum_in = 5'd7; in_valid = 1'b1;
    tick(1);                                  // E0 transfer
    in_valid = 1'b0;
    check_eq("s7.ready_lo", 32'(in_ready), 32'd0);
    tick(1);                                  // E1 conversion done
    check_eq("s7.ready_hi", 32'(in_ready), 32'd1);
    tick(1);                                  // E2
    check_disp("s7.units", 7'h07, 1'b0, 1'b0);
    tick(2);                                  // E4
    check_disp("s7.units_end", 7'h07, 1'b0, 1'b0);
    tick(1);                                  // E5
    check_disp("s7.tens", TENS_ZERO, 1'b1, 1'b1);
    tick(3);                                  // E8
    check_disp("s7.tens_end", TENS_ZERO, 1'b1, 1'b1);
    tick(1);                                  // E9
    check_disp("s7.units2", 7'h07, 1'b0, 1'b0);

    // sum_in = 30: four conversion cycles
    do_reset();
    sum_in = 5'd30; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("s30.ready_lo", 32'(in_ready), 32'd0);
      tick(1);
    end
    check_eq("s30.ready_lo4", 32'(in_ready), 32'd0);
    tick(1);                                  // E4 done
    check_eq("s30.ready_hi", 32'(in_ready), 32'd1);
    check_eq("s30.blank", 32'(seg), 32'h00);
    tick(1);                                  // E5
    check_disp("s30.tens", 7'h4F, 1'b1, 1'b1);
    tick(4);                                  // E9
    check_disp("s30.units", 7'h3F, 1'b0, 1'b0);

    // 12 showing, then 25 arrives mid tens phase
    do_reset();
    sum_in = 5'd12; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(3);                                  // E3
    check_disp("s12.units", 7'h5B, 1'b0, 1'b0);
    tick(1);                                  // E4
    sum_in = 5'd25; in_valid = 1'b1;
    tick(1);                                  // E5 transfer of 25
    in_valid = 1'b0;
    check_disp("s25.old_tens", 7'h06, 1'b1, 1'b1);
    check_eq("s25.ready_lo", 32'(in_ready), 32'd0);
    tick(2);                                  // E7
    check_disp("s25.old_tens2", 7'h06, 1'b1, 1'b1);
    check_eq("s25.ready_lo3", 32'(in_ready), 32'd0);
    tick(1);                                  // E8
    check_eq("s25.ready_hi", 32'(in_ready), 32'd1);
    tick(1);                                  // E9
    check_disp("s25.units", 7'h6D, 1'b0, 1'b0);
    tick(4);                                  // E13
    check_disp("s25.tens", 7'h5B, 1'b1, 1'b1);

    // in_valid during CONVERT is ignored
    do_reset();
    sum_in = 5'd28; in_valid = 1'b1;
    tick(1);
    sum_in = 5'd3;
    tick(2);                                  // E2 still converting
    check_eq("ign.ready_lo", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick(2);                                  // E4
    check_disp("ign.units", 7'h7F, 1'b0, 1'b0);
    tick(1);                                  // E5
    check_disp("ign.tens", 7'h5B, 1'b1, 1'b1);

    // ena low for 10 cycles mid-SHOW freezes everything
    ena = 1'b0; sum_in = 5'd7; in_valid = 1'b1;
    #1;
    check_eq("ena.ready_lo", 32'(in_ready), 32'd0);
    tick(10);
    check_disp("ena.frozen", 7'h5B, 1'b1, 1'b1);
    in_valid = 1'b0; ena = 1'b1;
    #1;
    check_eq("ena.ready_hi", 32'(in_ready), 32'd1);
    tick(3);
    check_disp("ena.tens_cont", 7'h5B, 1'b1, 1'b1);
    tick(1);
    check_disp("ena.units", 7'h7F, 1'b0, 1'b0);

    // Reset during conversion of 28
    do_reset();
    sum_in = 5'd28; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check_disp("rconv.blank", 7'h00, 1'b0, 1'b0);
    check_eq("rconv.ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick(8);
    check_disp("rconv.still_blank", 7'h00, 1'b0, 1'b0);

    // 31 with in_valid held high: repeated conversions, same display
    do_reset();
    sum_in = 5'd31; in_valid = 1'b1;
    tick(4);                                  // E3
    check_eq("s31.ready_lo", 32'(in_ready), 32'd0);
    tick(1);                                  // E4 done
    check_eq("s31.ready_hi", 32'(in_ready), 32'd1);
    tick(1);                                  // E5 retrigger
    check_eq("s31.retrig", 32'(in_ready), 32'd0);
    check_disp("s31.tens", 7'h4F, 1'b1, 1'b1);
    tick(4);                                  // E9
    check_disp("s31.units", 7'h06, 1'b0, 1'b0);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
